// File: rtl/recirc_mux_rx_pkg.sv
// Shared defaults and helpers for the recirculating-mux multi-channel CDC receiver.
package recirc_mux_rx_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_CHANNELS    = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Channel index width; a single channel still needs one bit to carry an index.
    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/recirc_mux_rx_arb_if.sv
// Output word handshake of the receiver: valid/ready with data and source channel.
interface recirc_mux_rx_arb_if
    import recirc_mux_rx_pkg::*;
#(
    parameter int unsigned g_width    = DEF_WIDTH,
    parameter int unsigned g_channels = DEF_CHANNELS
) ();

    localparam int unsigned CHAN_W = chan_idx_w(g_channels);

    logic                o_valid;
    logic                i_ready;
    logic [g_width-1:0]  o_data;
    logic [CHAN_W-1:0]   o_chan;

    modport master (output o_valid, output o_data, output o_chan, input  i_ready);
    modport slave  (input  o_valid, input  o_data, input  o_chan, output i_ready);

endinterface

// File: rtl/recirc_mux_rx_chan.sv
// One receive channel: toggle synchroniser, edge detect, recirculating hold register,
// pending and sticky overflow bits. Properties compile only with RECIRC_MUX_RX_FORMAL_EN.
module recirc_mux_rx_chan
    import recirc_mux_rx_pkg::*;
#(
    parameter int unsigned g_width       = DEF_WIDTH,
    parameter int unsigned g_sync_stages = DEF_SYNC_STAGES
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_toggle_A,
    input  logic [g_width-1:0] i_data_A,
    input  logic               i_grant,
    input  logic               i_clr_ovf,
    output logic               o_pending,
    output logic               o_overflow,
    output logic [g_width-1:0] o_hold
);

    logic [g_sync_stages-1:0] sync_q, sync_d;
    logic                     edge_q, edge_d;
    logic [g_width-1:0]       hold_q, hold_d;
    logic                     pending_q, pending_d;
    logic                     ovf_q, ovf_d;
    logic                     capture;

    // Data is never synchronised; it only enters through the hold-register mux on a capture.
    always_comb begin
        sync_d    = {sync_q[g_sync_stages-2:0], i_toggle_A};
        edge_d    = sync_q[g_sync_stages-1];
        capture   = sync_q[g_sync_stages-1] ^ edge_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (i_clr_ovf) ovf_d = 1'b0;
        if (i_grant)   pending_d = 1'b0;
        if (capture) begin
            // A same-edge grant frees the holding slot, so the new word can replace the old one.
            if (!pending_q || i_grant) begin
                hold_d    = i_data_A;
                pending_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            edge_q    <= edge_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_pending  = pending_q;
    assign o_overflow = ovf_q;
    assign o_hold     = hold_q;

`ifdef RECIRC_MUX_RX_FORMAL_EN
    p_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !capture |=> $stable(hold_q));
`endif

endmodule

// File: rtl/recirc_mux_rx_arb.sv
// Multi-channel toggle-handshake receiver: per-channel capture, round-robin arbiter and
// registered output stage. Embedded properties compile only with RECIRC_MUX_RX_FORMAL_EN.
module recirc_mux_rx_arb
    import recirc_mux_rx_pkg::*;
#(
    parameter int unsigned g_width       = DEF_WIDTH,
    parameter int unsigned g_channels    = DEF_CHANNELS,
    parameter int unsigned g_sync_stages = DEF_SYNC_STAGES
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [g_channels-1:0]         i_toggle_A,
    input  logic [g_channels*g_width-1:0] i_data_A,
    output logic [g_channels-1:0]         o_overflow,
    input  logic                          i_clr_ovf,
    recirc_mux_rx_arb_if.master           out_if
);

    localparam int unsigned CHAN_W = chan_idx_w(g_channels);

    logic [g_channels-1:0]              pending;
    logic [g_channels-1:0]              grant;
    logic [g_channels-1:0]              ovf;
    logic [g_channels-1:0][g_width-1:0] hold;

    logic               valid_q, valid_d;
    logic [g_width-1:0] data_q, data_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic [CHAN_W-1:0]  last_q, last_d;
    logic [CHAN_W-1:0]  gidx;
    logic [CHAN_W-1:0]  cand;
    logic               loadable;
    logic               found;

    for (genvar c = 0; c < g_channels; c++) begin : g_chan
        recirc_mux_rx_chan #(
            .g_width       (g_width),
            .g_sync_stages (g_sync_stages)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_toggle_A (i_toggle_A[c]),
            .i_data_A   (i_data_A[c*g_width +: g_width]),
            .i_grant    (grant[c]),
            .i_clr_ovf  (i_clr_ovf),
            .o_pending  (pending[c]),
            .o_overflow (ovf[c]),
            .o_hold     (hold[c])
        );
    end

    // Round-robin search starts just after the last granted channel and wraps.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        chan_d   = chan_q;
        last_d   = last_q;
        grant    = '0;
        gidx     = '0;
        cand     = '0;
        found    = 1'b0;
        loadable = !valid_q || out_if.i_ready;
        for (int k = 1; k <= int'(g_channels); k++) begin
            cand = CHAN_W'((int'(last_q) + k) % int'(g_channels));
            if (!found && pending[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        if (loadable) begin
            valid_d = found;
            if (found) begin
                grant[gidx] = 1'b1;
                data_d      = hold[gidx];
                chan_d      = gidx;
                last_d      = gidx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= CHAN_W'(g_channels - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
        end
    end

    assign out_if.o_valid = valid_q;
    assign out_if.o_data  = data_q;
    assign out_if.o_chan  = chan_q;
    assign o_overflow     = ovf;

`ifdef RECIRC_MUX_RX_FORMAL_EN
    p_out_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (valid_q && !out_if.i_ready) |=> (valid_q && $stable(data_q) && $stable(chan_q)));
    p_valid_cause: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $rose(valid_q) |-> $past(|pending));
    p_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(grant));
`endif

endmodule

// File: tb/tb_recirc_mux_rx_arb.sv
// Directed scoreboard bench for recirc_mux_rx_arb at 8-bit width, 4 channels, 2 sync stages.
module tb_recirc_mux_rx_arb;

    localparam int unsigned W  = 8;
    localparam int unsigned C  = 4;
    localparam int unsigned S  = 2;
    localparam int unsigned CW = 2;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [C-1:0]   tog;
    logic [C*W-1:0] dat;
    logic [C-1:0]   ovf;
    logic           clr;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    recirc_mux_rx_arb_if #(.g_width(W), .g_channels(C)) bus ();

    recirc_mux_rx_arb #(
        .g_width       (W),
        .g_channels    (C),
        .g_sync_stages (S)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_toggle_A (tog),
        .i_data_A   (dat),
        .o_overflow (ovf),
        .i_clr_ovf  (clr),
        .out_if     (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; a word handed over at that edge is checked against the scoreboard.
    task automatic tick();
        logic acc;
        exp_t got;
        exp_t e;
        acc    = bus.o_valid && bus.i_ready;
        got.ch = bus.o_chan;
        got.d  = bus.o_data;
        @(posedge clk);
        #1;
        if (acc) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_word observed=ch%0d/%02h expected=none", got.ch, got.d);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_chan", 64'(got.ch), 64'(e.ch));
                chk("sb_data", 64'(got.d), 64'(e.d));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int c, input logic [W-1:0] d, input bit emit);
        exp_t e;
        dat[c*W +: W] = d;
        tog[c]        = ~tog[c];
        if (emit) begin
            e.ch = CW'(c);
            e.d  = d;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        tog         = '0;
        dat         = '0;
        clr         = 1'b0;
        bus.i_ready = 1'b0;
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        tog         = '0;
        dat         = '0;
        clr         = 1'b0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_data", 64'(bus.o_data), 64'd0);
        chk("rst_chan", 64'(bus.o_chan), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;

        // Single word latency and one-cycle valid
        bus.i_ready = 1'b1;
        send(1, 8'hA5, 1'b1);
        ticks(3);
        chk("lat_edge3_valid", 64'(bus.o_valid), 64'd0);
        tick();
        chk("lat_edge4_valid", 64'(bus.o_valid), 64'd1);
        chk("lat_data", 64'(bus.o_data), 64'hA5);
        chk("lat_chan", 64'(bus.o_chan), 64'd1);
        tick();
        chk("lat_one_cycle", 64'(bus.o_valid), 64'd0);

        // Three simultaneous channels drain back-to-back in round-robin order
        do_reset();
        bus.i_ready = 1'b1;
        send(0, 8'h11, 1'b1);
        send(2, 8'h22, 1'b1);
        send(3, 8'h33, 1'b1);
        ticks(4);
        chk("rr_first_valid", 64'(bus.o_valid), 64'd1);
        chk("rr_first_chan", 64'(bus.o_chan), 64'd0);
        tick();
        chk("rr_second_chan", 64'(bus.o_chan), 64'd2);
        tick();
        chk("rr_third_chan", 64'(bus.o_chan), 64'd3);
        chk("rr_third_valid", 64'(bus.o_valid), 64'd1);
        tick();
        chk("rr_drained", 64'(bus.o_valid), 64'd0);

        // Stalled output: held word stable, a third word overflows and is dropped
        do_reset();
        send(2, 8'h40, 1'b1);
        ticks(4);
        chk("ovf_out_valid", 64'(bus.o_valid), 64'd1);
        chk("ovf_out_data", 64'(bus.o_data), 64'h40);
        send(2, 8'h41, 1'b1);
        ticks(4);
        chk("ovf_not_yet", 64'(ovf), 64'd0);
        chk("ovf_data_stable", 64'(bus.o_data), 64'h40);
        send(2, 8'h42, 1'b0);
        ticks(3);
        chk("ovf_set", 64'(ovf), 64'b0100);
        chk("ovf_data_held", 64'(bus.o_data), 64'h40);
        chk("ovf_chan_held", 64'(bus.o_chan), 64'd2);
        send(2, 8'h43, 1'b0);
        ticks(2);
        clr = 1'b1;
        tick();
        chk("ovf_set_beats_clr", 64'(ovf), 64'b0100);
        tick();
        chk("ovf_cleared", 64'(ovf), 64'd0);
        clr         = 1'b0;
        bus.i_ready = 1'b1;
        ticks(3);
        chk("ovf_drained", 64'(bus.o_valid), 64'd0);
        chk("ovf_sb_empty", 64'(sb.size()), 64'd0);

        // Capture coinciding with the grant of the same channel keeps both words
        do_reset();
        send(3, 8'h50, 1'b1);
        ticks(4);
        chk("same_first_data", 64'(bus.o_data), 64'h50);
        send(3, 8'h51, 1'b1);
        ticks(3);
        send(3, 8'h52, 1'b1);
        ticks(2);
        bus.i_ready = 1'b1;
        tick();
        chk("same_second_data", 64'(bus.o_data), 64'h51);
        chk("same_second_valid", 64'(bus.o_valid), 64'd1);
        tick();
        chk("same_third_data", 64'(bus.o_data), 64'h52);
        tick();
        chk("same_drained", 64'(bus.o_valid), 64'd0);
        chk("same_no_ovf", 64'(ovf), 64'd0);
        chk("same_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with words pending and an overflow flag set
        do_reset();
        send(0, 8'h10, 1'b0);
        send(1, 8'h20, 1'b0);
        send(2, 8'h30, 1'b0);
        send(3, 8'h40, 1'b0);
        ticks(4);
        send(1, 8'h21, 1'b0);
        ticks(3);
        chk("mid_ovf_before", 64'(ovf), 64'b0010);
        chk("mid_valid_before", 64'(bus.o_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("mid_async_valid", 64'(bus.o_valid), 64'd0);
        chk("mid_async_ovf", 64'(ovf), 64'd0);
        tog = '0;
        dat = '0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;
        ticks(8);
        chk("mid_no_stale", 64'(bus.o_valid), 64'd0);

        // Toggle already high at reset release produces exactly one word
        rst_n = 1'b0;
        send(1, 8'h77, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ticks(3);
        chk("rel_edge3_valid", 64'(bus.o_valid), 64'd0);
        tick();
        chk("rel_edge4_valid", 64'(bus.o_valid), 64'd1);
        chk("rel_data", 64'(bus.o_data), 64'h77);
        ticks(4);
        chk("rel_single", 64'(bus.o_valid), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
